nmea_rmc_parser: RTL
====================

# nmea_rmc_parser

Byte-stream NMEA 0183 parser between the UART receiver and the LCD display/clock logic. Consumes one received byte per `rx_valid` strobe and locates `$xxRMC` sentences. It validates the XOR checksum, then publishes UTC time, date and fix status as BCD digits. In parallel it writes every field character into the terminal character RAM at a row/column address.

## Interface
- `MAX_LEN`, 82: maximum sentence length in bytes, counting `$` through the second checksum digit; longer sentences abort.
- `clk`  in  1  system clock (pixel clock domain).
- `rst_n`  in  1  reset, synchronous, active-low.
- `rx_byte`  in  8  received byte; valid only when `rx_valid`=1.
- `rx_valid`  in  1  one-cycle strobe per byte; consecutive strobes are at least 2 cycles apart.
- `time_bcd`  out  24  hh,mm,ss digits, MSB-first (`[23:20]`=h tens).
- `date_bcd`  out  24  dd,mm,yy digits, MSB-first.
- `fix_ok`  out  1  status field was `A` in the last accepted sentence.
- `upd`  out  1  one-cycle pulse when outputs are refreshed.
- `cksum_err_cnt`  out  8  saturating count of checksum mismatches.
- `wr_en`  out  1  terminal RAM write strobe.
- `wr_addr`  out  10  `{field_idx[4:0], char_idx[4:0]}`.
- `wr_data`  out  8  character to write.

## Operation
- States: IDLE, HDR, FIELD, CK_HI, CK_LO.
- IDLE: wait for `$`; on `$` clear checksum accumulator, byte counter and header shift register; go to HDR.
- HDR: XOR each byte into the checksum and shift it into a 5-byte header register. On `,`:
  - Header bytes 3..5 = `RMC` (any talker): field_idx←1, char_idx←0, go to FIELD.
  - Otherwise: return to IDLE.
- FIELD: XOR every byte except `*` into the checksum.
  - `,`: field_idx+1 (saturate at 31), char_idx←0.
  - `*`: go to CK_HI.
  - Other bytes: write to terminal RAM at the current address, then char_idx+1 saturating at 31. Writes at char_idx=31 still overwrite column 31.
- Field capture into shadow registers; outputs are not touched until acceptance:
  - Field 1: chars 0..5 → time digits. Chars after index 5 (fractional seconds) are ignored.
  - Field 2: `fix_shadow` = (char0 == `A`).
  - Field 9: chars 0..5 → date digits.
  - A non-digit in any captured time/date position sets a sentence error flag.
  - If field 1 or field 9 has fewer than 6 chars, the error flag is set.
- CK_HI / CK_LO: each byte must be a hex digit, `0-9`, `A-F` or `a-f`; a non-hex byte aborts to IDLE with no update.
- After CK_LO, compare the received checksum with the accumulator:
  - Match and no error flag: copy shadow → outputs, pulse `upd`.
  - Mismatch: `cksum_err_cnt`+1, saturating at 255; outputs are unchanged.
  - Either way, return to IDLE.
- `$` in any non-IDLE state restarts the sentence (HDR, accumulator cleared). No update and no error count.
- Byte counter reaching `MAX_LEN` without completing CK_LO aborts to IDLE; no update.
- CR/LF outside IDLE are ordinary bytes and corrupt the checksum, so the sentence fails.
- Terminal writes issued before an abort or a bad checksum are not retracted.

## Timing
- Reset values: `time_bcd`=0, `date_bcd`=0, `fix_ok`=0, `upd`=0, `cksum_err_cnt`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0. State IDLE, shadows cleared.
- Reset asserted mid-sentence: state returns to IDLE on the next edge and the partial sentence is discarded.
- `wr_en`/`wr_addr`/`wr_data` are registered: asserted the cycle after the `rx_valid` cycle, for exactly 1 cycle.
- `upd` and the new output values appear the cycle after the `rx_valid` of the second checksum digit. `upd` is high for exactly 1 cycle.
- Outputs are stable between `upd` pulses.
- `cksum_err_cnt` increments in the same cycle an accepted sentence would pulse `upd`.

## Test plan
- Send `$GPRMC,123519,A,4807.038,N,01131.000,E,022.4,084.4,230394,003.1,W*6A`:
  - `time_bcd`=0x123519, `date_bcd`=0x230394, `fix_ok`=1.
  - One `upd` pulse one cycle after the `A` byte.
  - First write: `wr_addr`=0x020 (field 1, column 0), `wr_data`=`1`.
- Same sentence with checksum `*6B`: no `upd`, outputs unchanged, `cksum_err_cnt`=1. Repeat 300× → `cksum_err_cnt` saturates at 255.
- Same sentence with lowercase `*6a` and status `V` (checksum adjusted to `*7D`): `upd` pulses, `fix_ok`=0.
- Send half a sentence, then a complete valid sentence starting with a new `$`: exactly one `upd`, with values from the second sentence.
- Send a `$GPGGA` sentence: no writes, no `upd`. Send a 90-byte sentence with no `*`: abort at 82 bytes, no `upd`.
- Assert `rst_n`=0 for 1 cycle mid-field 1: all outputs return to reset values. The next full valid sentence is parsed correctly.

Source files
------------

// File: rtl/nmea_rmc_parser.sv
// NMEA 0183 RMC sentence parser: publishes checksum-validated UTC time, date and
// fix status as BCD, and mirrors every field character into the terminal RAM.
module nmea_rmc_parser #(
    parameter int MAX_LEN = 82
) (
    input  logic        clk,
    input  logic        rst_n,
    // rx_byte is meaningful only in a cycle with rx_valid high. There is no
    // back-pressure: every strobed byte is consumed in the cycle it is strobed.
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic [23:0] time_bcd,
    output logic [23:0] date_bcd,
    output logic        fix_ok,
    output logic        upd,
    output logic [7:0]  cksum_err_cnt,
    output logic        wr_en,
    output logic [9:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic [2:0]  dbg_state
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        FIELD = 3'd2,
        CK_HI = 3'd3,
        CK_LO = 3'd4
    } state_t;

    localparam logic [7:0]  CH_DOLLAR = 8'h24;
    localparam logic [7:0]  CH_COMMA  = 8'h2C;
    localparam logic [7:0]  CH_STAR   = 8'h2A;
    localparam logic [7:0]  CH_A      = 8'h41;
    localparam logic [23:0] HDR_RMC   = 24'h524D43;
    localparam logic [6:0]  LAST_CNT  = 7'(MAX_LEN - 1);

    state_t      state;
    logic [7:0]  acc;
    logic [6:0]  byte_cnt;
    logic [23:0] hdr_tail;   // only the last three header bytes decide RMC
    logic [4:0]  field_idx;
    logic [4:0]  char_idx;
    logic [3:0]  ck_hi;
    logic [23:0] time_sh;
    logic [23:0] date_sh;
    logic        fix_sh;
    logic        sent_err;

    logic        is_digit;
    logic        is_hex;
    logic [3:0]  hex_nib;
    logic        cap_pos;
    logic        short_field;

    always_comb begin
        is_digit = (rx_byte >= 8'h30) && (rx_byte <= 8'h39);
        is_hex   = is_digit;
        hex_nib  = rx_byte[3:0];
        if (((rx_byte >= 8'h41) && (rx_byte <= 8'h46)) ||
            ((rx_byte >= 8'h61) && (rx_byte <= 8'h66))) begin
            is_hex  = 1'b1;
            hex_nib = rx_byte[3:0] + 4'd9;
        end
        cap_pos     = (char_idx < 5'd6);
        short_field = ((field_idx == 5'd1) || (field_idx == 5'd9)) && cap_pos;
    end

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            acc           <= 8'h00;
            byte_cnt      <= 7'd0;
            hdr_tail      <= 24'h0;
            field_idx     <= 5'd0;
            char_idx      <= 5'd0;
            ck_hi         <= 4'h0;
            time_sh       <= 24'h0;
            date_sh       <= 24'h0;
            fix_sh        <= 1'b0;
            sent_err      <= 1'b0;
            time_bcd      <= 24'h0;
            date_bcd      <= 24'h0;
            fix_ok        <= 1'b0;
            upd           <= 1'b0;
            cksum_err_cnt <= 8'h00;
            wr_en         <= 1'b0;
            wr_addr       <= 10'h000;
            wr_data       <= 8'h00;
        end else begin
            upd   <= 1'b0;
            wr_en <= 1'b0;
            if (rx_valid) begin
                if (rx_byte == CH_DOLLAR) begin
                    state    <= HDR;
                    acc      <= 8'h00;
                    byte_cnt <= 7'd1;
                    hdr_tail <= 24'h0;
                    fix_sh   <= 1'b0;
                    sent_err <= 1'b0;
                end else if ((state != IDLE) && (state != CK_LO) && (byte_cnt >= LAST_CNT)) begin
                    // this byte would be the last allowed one and cannot finish the sentence
                    state <= IDLE;
                end else begin
                    case (state)
                        IDLE: ;
                        HDR: begin
                            byte_cnt <= byte_cnt + 7'd1;
                            acc      <= acc ^ rx_byte;
                            hdr_tail <= {hdr_tail[15:0], rx_byte};
                            if (rx_byte == CH_COMMA) begin
                                if (hdr_tail == HDR_RMC) begin
                                    field_idx <= 5'd1;
                                    char_idx  <= 5'd0;
                                    state     <= FIELD;
                                end else begin
                                    state <= IDLE;
                                end
                            end
                        end
                        FIELD: begin
                            byte_cnt <= byte_cnt + 7'd1;
                            if (rx_byte == CH_STAR) begin
                                // ending before field 9 is complete means no valid date
                                if ((field_idx < 5'd9) || ((field_idx == 5'd9) && cap_pos))
                                    sent_err <= 1'b1;
                                state <= CK_HI;
                            end else if (rx_byte == CH_COMMA) begin
                                acc <= acc ^ rx_byte;
                                if (short_field)
                                    sent_err <= 1'b1;
                                field_idx <= (field_idx == 5'd31) ? 5'd31 : field_idx + 5'd1;
                                char_idx  <= 5'd0;
                            end else begin
                                acc     <= acc ^ rx_byte;
                                wr_en   <= 1'b1;
                                wr_addr <= {field_idx, char_idx};
                                wr_data <= rx_byte;
                                char_idx <= (char_idx == 5'd31) ? 5'd31 : char_idx + 5'd1;
                                if ((field_idx == 5'd1) && cap_pos) begin
                                    time_sh <= {time_sh[19:0], rx_byte[3:0]};
                                    if (!is_digit)
                                        sent_err <= 1'b1;
                                end
                                if ((field_idx == 5'd9) && cap_pos) begin
                                    date_sh <= {date_sh[19:0], rx_byte[3:0]};
                                    if (!is_digit)
                                        sent_err <= 1'b1;
                                end
                                if ((field_idx == 5'd2) && (char_idx == 5'd0))
                                    fix_sh <= (rx_byte == CH_A);
                            end
                        end
                        CK_HI: begin
                            byte_cnt <= byte_cnt + 7'd1;
                            ck_hi    <= hex_nib;
                            state    <= is_hex ? CK_LO : IDLE;
                        end
                        CK_LO: begin
                            byte_cnt <= byte_cnt + 7'd1;
                            state    <= IDLE;
                            if (is_hex) begin
                                if ({ck_hi, hex_nib} == acc) begin
                                    if (!sent_err) begin
                                        time_bcd <= time_sh;
                                        date_bcd <= date_sh;
                                        fix_ok   <= fix_sh;
                                        upd      <= 1'b1;
                                    end
                                end else if (cksum_err_cnt != 8'hFF) begin
                                    cksum_err_cnt <= cksum_err_cnt + 8'h01;
                                end
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end
endmodule
